// File: rtl/eth_sw_pkg.sv
// Shared constants and types for the Ethernet switch packet checker.
package eth_sw_pkg;

   // Bit positions inside each lane's sticky error vector
   localparam int ERR_SOP_IN_PKT = 0;
   localparam int ERR_EOP_NO_SOP = 1;
   localparam int ERR_RUNT       = 2;
   localparam int ERR_GIANT      = 3;
   localparam int ERR_W          = 4;

   // Default legal length window in words (64 B .. 1536 B at 32 bit)
   localparam int DEF_MIN_LEN = 16;
   localparam int DEF_MAX_LEN = 384;

   // Per-lane framing state
   typedef enum logic {
      LANE_IDLE   = 1'b0,
      LANE_IN_PKT = 1'b1
   } lane_state_e;

endpackage

// File: rtl/eth_sw_pkt_lane.sv
// Single-port framing checker: rebuilds packet boundaries from SOP/EOP,
// accumulates length and XOR signature, counts good packets and latches
// sticky protocol errors.
module eth_sw_pkt_lane
   import eth_sw_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MIN_LEN = DEF_MIN_LEN,
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W   = 32,
   parameter int LEN_W   = $clog2(MAX_LEN + 2)
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic [DATA_W-1:0] data,
   input  logic              sop,
   input  logic              eop,
   input  logic              stall,
   input  logic              clr,
   output logic              done,
   output logic [LEN_W-1:0]  len,
   output logic [DATA_W-1:0] sig,
   output logic              bad,
   output logic [CNT_W-1:0]  good_cnt,
   output logic [ERR_W-1:0]  err
);

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

   lane_state_e       state_q, state_d;
   logic [LEN_W-1:0]  acc_len_q, acc_len_d;
   logic [DATA_W-1:0] acc_sig_q, acc_sig_d;
   logic              done_q, done_d;
   logic [LEN_W-1:0]  plen_q, plen_d;
   logic [DATA_W-1:0] psig_q, psig_d;
   logic              bad_q, bad_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              close;

   // Next-state: framing FSM, accumulators, close reporting, stats update
   always_comb begin
      state_d   = state_q;
      acc_len_d = acc_len_q;
      acc_sig_d = acc_sig_q;
      done_d    = 1'b0;
      plen_d    = plen_q;
      psig_d    = psig_q;
      bad_d     = 1'b0;
      cnt_d     = cnt_q;
      err_d     = err_q;
      close     = 1'b0;

      if (!stall) begin
         if (sop) begin
            // A SOP always (re)starts accumulation; inside a packet the
            // old one is abandoned without a close.
            if (state_q == LANE_IN_PKT) begin
               err_d[ERR_SOP_IN_PKT] = 1'b1;
            end
            acc_len_d = LEN_ONE;
            acc_sig_d = data;
            if (eop) begin
               close   = 1'b1;
               state_d = LANE_IDLE;
            end else begin
               state_d = LANE_IN_PKT;
            end
         end else if (state_q == LANE_IN_PKT) begin
            if (acc_len_q != LEN_SAT) begin
               acc_len_d = acc_len_q + LEN_ONE;
            end
            acc_sig_d = acc_sig_q ^ data;
            if (eop) begin
               close   = 1'b1;
               state_d = LANE_IDLE;
            end
         end else if (eop) begin
            err_d[ERR_EOP_NO_SOP] = 1'b1;
         end
      end

      if (close) begin
         done_d = 1'b1;
         plen_d = acc_len_d;
         psig_d = acc_sig_d;
         if (acc_len_d < LEN_MIN) begin
            bad_d           = 1'b1;
            err_d[ERR_RUNT] = 1'b1;
         end else if (acc_len_d > LEN_MAX) begin
            bad_d            = 1'b1;
            err_d[ERR_GIANT] = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (clr) begin
         cnt_d = '0;
         err_d = '0;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= LANE_IDLE;
         acc_len_q <= '0;
         acc_sig_q <= '0;
         done_q    <= 1'b0;
         plen_q    <= '0;
         psig_q    <= '0;
         bad_q     <= 1'b0;
         cnt_q     <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_len_q <= acc_len_d;
         acc_sig_q <= acc_sig_d;
         done_q    <= done_d;
         plen_q    <= plen_d;
         psig_q    <= psig_d;
         bad_q     <= bad_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   assign done     = done_q;
   assign len      = plen_q;
   assign sig      = psig_q;
   assign bad      = bad_q;
   assign good_cnt = cnt_q;
   assign err      = err_q;

endmodule

// File: rtl/eth_sw_pkt_checker.sv
// N-port passive framing checker and statistics block; one independent
// eth_sw_pkt_lane per port, flattened buses packed/unpacked here.
module eth_sw_pkt_checker
   import eth_sw_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = 32,
   parameter int MIN_LEN   = DEF_MIN_LEN,
   parameter int MAX_LEN   = DEF_MAX_LEN,
   parameter int CNT_W     = 32,
   localparam int LEN_W    = $clog2(MAX_LEN + 2)
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic [NUM_PORTS*DATA_W-1:0] inData,
   input  logic [NUM_PORTS-1:0]        inSop,
   input  logic [NUM_PORTS-1:0]        inEop,
   input  logic [NUM_PORTS-1:0]        portStall,
   input  logic                        clrStats,
   output logic [NUM_PORTS-1:0]        pktDone,
   output logic [NUM_PORTS*LEN_W-1:0]  pktLen,
   output logic [NUM_PORTS*DATA_W-1:0] pktSig,
   output logic [NUM_PORTS-1:0]        pktBad,
   output logic [NUM_PORTS*CNT_W-1:0]  goodCnt,
   output logic [NUM_PORTS*ERR_W-1:0]  errSticky
);

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
      eth_sw_pkt_lane #(
         .DATA_W  (DATA_W),
         .MIN_LEN (MIN_LEN),
         .MAX_LEN (MAX_LEN),
         .CNT_W   (CNT_W),
         .LEN_W   (LEN_W)
      ) u_lane (
         .clk      (clk),
         .resetN   (resetN),
         .data     (inData[p*DATA_W +: DATA_W]),
         .sop      (inSop[p]),
         .eop      (inEop[p]),
         .stall    (portStall[p]),
         .clr      (clrStats),
         .done     (pktDone[p]),
         .len      (pktLen[p*LEN_W +: LEN_W]),
         .sig      (pktSig[p*DATA_W +: DATA_W]),
         .bad      (pktBad[p]),
         .good_cnt (goodCnt[p*CNT_W +: CNT_W]),
         .err      (errSticky[p*ERR_W +: ERR_W])
      );
   end

endmodule

// File: tb/tb_eth_sw_pkt_checker.sv
// Self-checking bench for eth_sw_pkt_checker: directed packets plus random
// traffic, compared every cycle against a behavioural packet model.
module tb_eth_sw_pkt_checker;
   localparam int NP   = 2;
   localparam int DW   = 32;
   localparam int MINL = 16;
   localparam int MAXL = 384;
   localparam int CW   = 32;
   localparam int LW   = $clog2(MAXL + 2);

   logic              clk = 1'b0;
   logic              resetN = 1'b1;
   logic [NP*DW-1:0]  inData = '0;
   logic [NP-1:0]     inSop = '0, inEop = '0, portStall = '0;
   logic              clrStats = 1'b0;
   logic [NP-1:0]     pktDone, pktBad;
   logic [NP*LW-1:0]  pktLen;
   logic [NP*DW-1:0]  pktSig;
   logic [NP*CW-1:0]  goodCnt;
   logic [NP*4-1:0]   errSticky;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   // model packet state
   bit          m_in  [NP];
   int unsigned m_len [NP];
   logic [DW-1:0] m_sig [NP];
   // model outputs after the upcoming edge
   bit          n_done[NP], n_bad[NP];
   int unsigned n_len [NP];
   logic [DW-1:0] n_sig [NP];
   logic [CW-1:0] n_good[NP];
   logic [3:0]  n_err [NP];
   // model outputs currently expected on the DUT
   bit          e_done[NP], e_bad[NP];
   int unsigned e_len [NP];
   logic [DW-1:0] e_sig [NP];
   logic [CW-1:0] e_good[NP];
   logic [3:0]  e_err [NP];

   eth_sw_pkt_checker #(
      .NUM_PORTS (NP),
      .DATA_W    (DW),
      .MIN_LEN   (MINL),
      .MAX_LEN   (MAXL),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .resetN    (resetN),
      .inData    (inData),
      .inSop     (inSop),
      .inEop     (inEop),
      .portStall (portStall),
      .clrStats  (clrStats),
      .pktDone   (pktDone),
      .pktLen    (pktLen),
      .pktSig    (pktSig),
      .pktBad    (pktBad),
      .goodCnt   (goodCnt),
      .errSticky (errSticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // compare DUT against the model every cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         for (int p = 0; p < NP; p++) begin
            chk($sformatf("pktDone[%0d]", p),   64'(pktDone[p]),                64'(e_done[p]));
            chk($sformatf("pktBad[%0d]", p),    64'(pktBad[p]),                 64'(e_bad[p]));
            chk($sformatf("pktLen[%0d]", p),    64'(pktLen[p*LW +: LW]),        64'(e_len[p]));
            chk($sformatf("pktSig[%0d]", p),    64'(pktSig[p*DW +: DW]),        64'(e_sig[p]));
            chk($sformatf("goodCnt[%0d]", p),   64'(goodCnt[p*CW +: CW]),       64'(e_good[p]));
            chk($sformatf("errSticky[%0d]", p), 64'(errSticky[p*4 +: 4]),       64'(e_err[p]));
         end
      end
   end

   task automatic close_pkt(input int p);
      m_in[p]   = 0;
      n_done[p] = 1;
      n_len[p]  = m_len[p];
      n_sig[p]  = m_sig[p];
      if (m_len[p] < MINL) begin
         n_bad[p]    = 1;
         n_err[p][2] = 1'b1;
      end else if (m_len[p] > MAXL) begin
         n_bad[p]    = 1;
         n_err[p][3] = 1'b1;
      end else begin
         n_good[p] = n_good[p] + 1;
      end
   endtask

   // apply the packet rules to the inputs presented this cycle
   task automatic model_step();
      for (int p = 0; p < NP; p++) begin
         logic [DW-1:0] d;
         d = inData[p*DW +: DW];
         n_done[p] = 0;
         n_bad[p]  = 0;
         if (!portStall[p]) begin
            if (inSop[p]) begin
               if (m_in[p]) n_err[p][0] = 1'b1;
               m_len[p] = 1;
               m_sig[p] = d;
               m_in[p]  = 1;
               if (inEop[p]) close_pkt(p);
            end else if (m_in[p]) begin
               if (m_len[p] <= MAXL) m_len[p] = m_len[p] + 1;
               m_sig[p] = m_sig[p] ^ d;
               if (inEop[p]) close_pkt(p);
            end else if (inEop[p]) begin
               n_err[p][1] = 1'b1;
            end
         end
         if (clrStats) begin
            n_good[p] = '0;
            n_err[p]  = '0;
         end
      end
   endtask

   task automatic cyc(input logic [NP-1:0] s, input logic [NP-1:0] e, input logic [NP-1:0] st,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic c);
      inSop = s; inEop = e; portStall = st; inData = {d1, d0}; clrStats = c;
      model_step();
      @(posedge clk);
      #1;
      e_done = n_done; e_bad = n_bad; e_len = n_len;
      e_sig  = n_sig;  e_good = n_good; e_err = n_err;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc('0, '0, '0, '0, '0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      resetN = 1'b0;
      inSop = '0; inEop = '0; portStall = '0; clrStats = 1'b0;
      for (int p = 0; p < NP; p++) begin
         m_in[p] = 0; m_len[p] = 0; m_sig[p] = '0;
         n_done[p] = 0; n_bad[p] = 0; n_len[p] = 0; n_sig[p] = '0; n_good[p] = '0; n_err[p] = '0;
      end
      e_done = n_done; e_bad = n_bad; e_len = n_len;
      e_sig  = n_sig;  e_good = n_good; e_err = n_err;
      chk_en = 1;
      repeat (n) @(posedge clk);
      #1;
      resetN = 1'b1;
   endtask

   // packet of len words, data base+1..base+len, on ports in mask m
   task automatic burst(input logic [NP-1:0] m, input int len, input int base, input bit eop,
                        input int st_at, input int st_n, input bit clr_last);
      for (int i = 0; i < len; i++) begin
         logic [DW-1:0] d;
         logic [NP-1:0] s, e;
         d = DW'(base + i + 1);
         s = (i == 0) ? m : '0;
         e = (eop && i == len - 1) ? m : '0;
         if (i == st_at) repeat (st_n) cyc(s, e, m, d, d, 1'b0);
         cyc(s, e, '0, d, d, clr_last && (i == len - 1));
      end
   endtask

   initial begin
      #1;
      do_reset(2);
      chk("rst_done", 64'(pktDone), 64'(0));
      chk("rst_err",  64'(errSticky), 64'(0));
      idle(2);

      // 16-word packet 1..16 on port 0
      burst(2'b01, 16, 0, 1, -1, 0, 0);
      chk("t1_done", 64'(pktDone[0]), 64'(1));
      chk("t1_len",  64'(pktLen[0 +: LW]), 64'(16));
      chk("t1_sig",  64'(pktSig[0 +: DW]), 64'h10);
      chk("t1_bad",  64'(pktBad[0]), 64'(0));
      chk("t1_good", 64'(goodCnt[0 +: CW]), 64'(1));
      idle(2);

      // 20-word packet on port 1 with a 3-cycle stall mid-packet
      burst(2'b10, 20, 50, 1, 10, 3, 0);
      chk("t2_len",   64'(pktLen[LW +: LW]), 64'(20));
      chk("t2_err",   64'(errSticky[4 +: 4]), 64'(0));
      chk("t2_good1", 64'(goodCnt[CW +: CW]), 64'(1));
      chk("t2_good0", 64'(goodCnt[0 +: CW]), 64'(1));
      idle(2);

      // SOP at word 5 of an open packet on port 0
      cyc('0, '0, '0, '0, '0, 1'b1);
      burst(2'b01, 4, 100, 0, -1, 0, 0);
      burst(2'b01, 16, 200, 1, -1, 0, 0);
      chk("t3_err",  64'(errSticky[0 +: 4]), 64'b0001);
      chk("t3_len",  64'(pktLen[0 +: LW]), 64'(16));
      chk("t3_good", 64'(goodCnt[0 +: CW]), 64'(1));
      idle(2);

      // orphan EOP, runt, giant on port 1
      cyc('0, 2'b10, '0, '0, '0, 1'b0);
      chk("t4_eop_err", 64'(errSticky[4 +: 4]), 64'b0010);
      chk("t4_eop_done", 64'(pktDone[1]), 64'(0));
      burst(2'b10, 8, 300, 1, -1, 0, 0);
      chk("t4_runt_err", 64'(errSticky[4 +: 4]), 64'b0110);
      chk("t4_runt_bad", 64'(pktBad[1]), 64'(1));
      chk("t4_runt_len", 64'(pktLen[LW +: LW]), 64'(8));
      chk("t4_runt_good", 64'(goodCnt[CW +: CW]), 64'(0));
      burst(2'b10, 400, 1000, 1, -1, 0, 0);
      chk("t4_giant_err", 64'(errSticky[4 +: 4]), 64'b1110);
      chk("t4_giant_len", 64'(pktLen[LW +: LW]), 64'(385));
      chk("t4_giant_bad", 64'(pktBad[1]), 64'(1));
      idle(2);

      // both ports close on the same cycle as clrStats
      cyc('0, '0, '0, '0, '0, 1'b1);
      burst(2'b11, 16, 7, 1, -1, 0, 1);
      chk("t5_done", 64'(pktDone), 64'b11);
      chk("t5_len0", 64'(pktLen[0 +: LW]), 64'(16));
      chk("t5_len1", 64'(pktLen[LW +: LW]), 64'(16));
      chk("t5_good", 64'(goodCnt), 64'(0));
      chk("t5_err",  64'(errSticky), 64'(0));
      idle(2);

      // reset in the middle of a port 0 packet
      burst(2'b01, 5, 400, 0, -1, 0, 0);
      resetN = 1'b0;
      #1;
      chk("t6_rst_len",  64'(pktLen), 64'(0));
      chk("t6_rst_sig",  64'(pktSig), 64'(0));
      do_reset(2);
      burst(2'b01, 16, 500, 1, -1, 0, 0);
      chk("t6_good", 64'(goodCnt[0 +: CW]), 64'(1));
      chk("t6_err",  64'(errSticky), 64'(0));
      idle(2);

      // random traffic on both ports
      for (int k = 0; k < 3000; k++) begin
         logic [NP-1:0] s, e, st;
         for (int p = 0; p < NP; p++) begin
            s[p]  = ($urandom_range(0, 15) == 0);
            e[p]  = ($urandom_range(0, 19) == 0);
            st[p] = ($urandom_range(0, 3) == 0);
         end
         cyc(s, e, st, DW'($urandom), DW'($urandom), $urandom_range(0, 255) == 0);
      end
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_sw_pkt_checker.md
Name: eth_sw_pkt_checker

Overview:
- Parametrised N-port framing checker and statistics block for the Ethernet switch; one independent lane per port, default 2 (ports A/B).
- Passive: taps each port's data, SOP/EOP pulses and stall, and reconstructs packet boundaries.
- Counts good packets, reports per-packet length and XOR signature, and latches sticky protocol errors (SOP inside packet, orphan EOP, runt, giant).
- Sits on the switch input side, or on the output side with a second instance; read by the scoreboard and by status logic.

Parameters:
- NUM_PORTS, 2, number of independent port lanes.
- DATA_W, 32, data word width per port.
- MIN_LEN, 16, minimum legal packet length in words (64 B at 32 bit).
- MAX_LEN, 384, maximum legal packet length in words (1536 B at 32 bit).
- CNT_W, 32, good-packet counter width.

Ports:
- clk  input  1  clock
- resetN  input  1  asynchronous active-low reset
- inData  input  NUM_PORTS*DATA_W  per-port data, port p at [p*DATA_W +: DATA_W]
- inSop  input  NUM_PORTS  per-port start-of-packet pulse
- inEop  input  NUM_PORTS  per-port end-of-packet pulse
- portStall  input  NUM_PORTS  per-port stall; beat not transferred while high
- clrStats  input  1  synchronous clear of counters and sticky errors
- pktDone  output  NUM_PORTS  1-cycle pulse: packet closed (good or bad)
- pktLen  output  NUM_PORTS*LEN_W  length of last closed packet in words, LEN_W=$clog2(MAX_LEN+2)
- pktSig  output  NUM_PORTS*DATA_W  XOR of all data words of last closed packet
- pktBad  output  NUM_PORTS  qualifies pktDone: closed packet was runt or giant
- goodCnt  output  NUM_PORTS*CNT_W  good packets per port
- errSticky  output  NUM_PORTS*4  per port: [0] SOP_IN_PKT, [1] EOP_NO_SOP, [2] RUNT, [3] GIANT

Behaviour:
- Single clock clk; reset asynchronous and active-low on resetN. During reset all outputs are 0 and every lane is in IDLE.
- Beat rule: port p transfers a beat on a cycle with portStall[p]=0 AND (inSop[p]=1 OR lane state=IN_PKT). While stalled, all lane inputs are ignored (held values are not re-counted).
- Lane FSM states: IDLE, IN_PKT.
- IDLE, beat with sop:
  - len=1, sig=data.
  - If eop also set: close a 1-word packet and stay in IDLE.
  - Otherwise go to IN_PKT.
- IDLE, eop without sop, not stalled: set EOP_NO_SOP. No packet is closed; state unchanged.
- IN_PKT, beat without sop:
  - len increments, saturating at MAX_LEN+1; sig ^= data.
  - If eop set: close the packet and go to IDLE.
- IN_PKT, beat with sop:
  - Set SOP_IN_PKT; abandon the current packet (no pktDone, not counted).
  - Restart with len=1, sig=data.
  - If eop also set: close a 1-word packet and go to IDLE; otherwise stay in IN_PKT.
- Close:
  - Registered; pktDone, pktLen, pktSig and pktBad are valid 1 cycle after the EOP beat.
  - pktLen/pktSig hold until the next close.
  - len<MIN_LEN: pktBad=1, RUNT set.
  - len>MAX_LEN (saturated value MAX_LEN+1 reported): pktBad=1, GIANT set.
  - Otherwise goodCnt increments, wrapping modulo 2^CNT_W.
- Sticky errors stay set until clrStats or reset.
- clrStats zeroes goodCnt and errSticky next cycle and has priority over a same-cycle increment or error set. It does not affect FSM state, len, sig, pktLen or pktSig.
- Lanes are fully independent; simultaneous events on different ports never interact.
- Reset mid-packet drops the packet silently; no error is raised after release.

Decomposition:
- Package eth_sw_pkg holds:
  - error-bit index constants (ERR_SOP_IN_PKT=0, ERR_EOP_NO_SOP=1, ERR_RUNT=2, ERR_GIANT=3, ERR_W=4);
  - the lane state enum typedef;
  - default MIN_LEN/MAX_LEN constants.
- One sub-module, eth_sw_pkt_lane: single-port FSM, length/signature accumulation, counter and sticky flags.
- Top level generates NUM_PORTS lanes and packs/unpacks the flattened buses.

Test Plan:
- Port 0, 16-word packet, data 1..16, no stall -> pktDone[0] 1 cycle after EOP, pktLen=16, pktSig=0x10 (XOR of 1..16), pktBad=0, goodCnt[0]=1.
- Port 1, 20-word packet with portStall[1] high for 3 cycles mid-packet while SOP/EOP/data are held -> pktLen=20, no errors, goodCnt[1]=1, port 0 counters unchanged.
- Port 0, SOP at word 5 of an open packet, then 16 more words ending in EOP -> errSticky[0][0]=1, one pktDone, pktLen=16, goodCnt[0]=1.
- EOP pulse on idle port 1 -> errSticky[1][1]=1, no pktDone. Then an 8-word packet -> RUNT set, pktBad=1, pktLen=8, goodCnt unchanged. Then a 400-word packet -> GIANT set, pktLen=385.
- Both ports close packets on the same cycle, with clrStats asserted on that same cycle -> both pktDone pulse with correct pktLen, goodCnt stays 0, errSticky 0.
- resetN low for 2 cycles in the middle of a port 0 packet, then a fresh 16-word packet -> all outputs 0 during reset; after release goodCnt[0]=1 and no error bits set.
